// File: rtl/mem_if_arb_pkg.sv
// Shared types for the multi-channel memory interface arbiter.
//   mem_trans_e      : bus transfer type (IDLE / NONSEQ)
//   mem_resp_e       : bus response (OKAY / ERROR)
//   arb_mode_e       : arbitration policy (fixed priority / round-robin)
//   mem_if_arb_state_e : bus-side state (no transfer / transfer in data phase)
package mem_if_arb_pkg;

  typedef enum logic {
    TransIdle   = 1'b0,
    TransNonseq = 1'b1
  } mem_trans_e;

  typedef enum logic {
    RespOkay  = 1'b0,
    RespError = 1'b1
  } mem_resp_e;

  // Alias kept so callers may write the older name for a good response.
  localparam mem_resp_e RespSuccess = RespOkay;

  typedef enum logic {
    ArbFixed = 1'b0,
    ArbRr    = 1'b1
  } arb_mode_e;

  typedef enum logic {
    StIdle = 1'b0,
    StData = 1'b1
  } mem_if_arb_state_e;

endpackage

// File: rtl/mem_if_arb_arb_rr.sv
// Request arbiter: combinational grant with a registered round-robin pointer.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   en_i          : grant allowed this cycle (issue slot)
//   req_i         : per-channel requests
//   gnt_valid_o   : a grant is made this cycle
//   gnt_idx_o     : index of the granted channel
// In ArbFixed mode the pointer stays at zero, so the scan is lowest-index-first.
module mem_if_arb_arb_rr
  import mem_if_arb_pkg::*;
#(
  parameter int unsigned NumCh   = 2,
  parameter arb_mode_e   ArbMode = ArbFixed,
  parameter int unsigned IdxW    = (NumCh > 1) ? $clog2(NumCh) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [NumCh-1:0] req_i,
  output logic             gnt_valid_o,
  output logic [IdxW-1:0]  gnt_idx_o
);

  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [IdxW-1:0] cand;
  logic [IdxW-1:0] idx;
  logic            found;

  // Scan channels starting at the pointer, wrapping modulo NumCh.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int unsigned k = 0; k < NumCh; k++) begin
      if (ArbMode == ArbRr) begin
        cand = IdxW'((32'(ptr_q) + k) % NumCh);
      end else begin
        cand = IdxW'(k);
      end
      if (!found && req_i[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

  assign gnt_valid_o = en_i & found;
  assign gnt_idx_o   = idx;

  always_comb begin
    ptr_d = ptr_q;
    if (ArbMode == ArbRr && gnt_valid_o) begin
      ptr_d = IdxW'((32'(idx) + 1) % NumCh);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/mem_if_arb.sv
// Multi-channel front end to a single-outstanding, address/data pipelined bus.
//   clk_i, rst_ni      : clock, asynchronous active-low reset
//   req_i/write_i      : per-channel request and write enable (req held until ready_o)
//   addr_i/wdata_i     : per-channel address and write data
//   ready_o/err_o      : per-channel completion pulse and error qualifier
//   rdata_o            : per-channel read data (live on completion, latched afterwards)
//   mem_ready_i/resp_i : bus ready and response
//   mem_rdata_i        : bus read data
//   mem_addr_o/trans_o/write_o : bus address phase
//   mem_wdata_o        : bus write data, driven during the data phase
module mem_if_arb
  import mem_if_arb_pkg::*;
#(
  parameter int unsigned DWidth  = 32,
  parameter int unsigned NumCh   = 2,
  parameter arb_mode_e   ArbMode = ArbFixed
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NumCh-1:0]              req_i,
  input  logic [NumCh-1:0]              write_i,
  input  logic [NumCh-1:0][DWidth-1:0]  addr_i,
  input  logic [NumCh-1:0][DWidth-1:0]  wdata_i,
  output logic [NumCh-1:0]              ready_o,
  output logic [NumCh-1:0]              err_o,
  output logic [NumCh-1:0][DWidth-1:0]  rdata_o,
  input  logic                          mem_ready_i,
  input  logic                          mem_resp_i,
  input  logic [DWidth-1:0]             mem_rdata_i,
  output logic [DWidth-1:0]             mem_addr_o,
  output logic                          mem_trans_o,
  output logic                          mem_write_o,
  output logic [DWidth-1:0]             mem_wdata_o
);

  localparam int unsigned IdxW = (NumCh > 1) ? $clog2(NumCh) : 1;

  mem_if_arb_state_e              state_q, state_d;
  logic [IdxW-1:0]                owner_q, owner_d;
  logic                           write_q, write_d;
  logic [DWidth-1:0]              wdata_q, wdata_d;
  logic [DWidth-1:0]              addr_q, addr_d;
  logic [NumCh-1:0][DWidth-1:0]   rdata_q, rdata_d;

  logic            completing;
  logic            gnt_valid;
  logic [IdxW-1:0] gnt_idx;

  // A slot opens whenever the bus is ready: idle, or the data phase finishing.
  assign completing = (state_q == StData) && mem_ready_i;

  mem_if_arb_arb_rr #(
    .NumCh   (NumCh),
    .ArbMode (ArbMode),
    .IdxW    (IdxW)
  ) u_arb (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .en_i        (mem_ready_i),
    .req_i       (req_i),
    .gnt_valid_o (gnt_valid),
    .gnt_idx_o   (gnt_idx)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    write_d     = write_q;
    wdata_d     = wdata_q;
    addr_d      = addr_q;
    rdata_d     = rdata_q;
    rdata_o     = rdata_q;
    ready_o     = '0;
    err_o       = '0;
    mem_trans_o = TransIdle;
    mem_addr_o  = addr_q;  // holds the last issued address through wait states
    mem_write_o = 1'b0;

    if (completing) begin
      ready_o[owner_q] = 1'b1;
      err_o[owner_q]   = (mem_resp_i == RespError);
      if (!write_q) begin
        rdata_o[owner_q] = mem_rdata_i;
        rdata_d[owner_q] = mem_rdata_i;
      end
      state_d = StIdle;
    end

    // Completing owner may be re-granted here with its next request.
    if (gnt_valid) begin
      mem_trans_o = TransNonseq;
      mem_addr_o  = addr_i[gnt_idx];
      mem_write_o = write_i[gnt_idx];
      owner_d     = gnt_idx;
      write_d     = write_i[gnt_idx];
      wdata_d     = wdata_i[gnt_idx];
      addr_d      = addr_i[gnt_idx];
      state_d     = StData;
    end
  end

  assign mem_wdata_o = (state_q == StData) ? wdata_q : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      owner_q <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      addr_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      addr_q  <= addr_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_if_arb.sv
module tb_mem_if_arb;
  import mem_if_arb_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic [3:0]       req, wr;
  logic [3:0][31:0] addr, wdata;
  logic             mr, resp;
  logic [31:0]      mrdata;

  // Fixed-priority, 2-channel instance
  logic [1:0]       f_ready, f_err;
  logic [1:0][31:0] f_rdata;
  logic [31:0]      f_addr, f_wdata;
  logic             f_trans, f_write;
  // Round-robin, 4-channel instance
  logic [3:0]       r_ready, r_err;
  logic [3:0][31:0] r_rdata;
  logic [31:0]      r_addr, r_wdata;
  logic             r_trans, r_write;

  mem_if_arb #(.DWidth(32), .NumCh(2), .ArbMode(ArbFixed)) u_fix (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req[1:0]), .write_i(wr[1:0]),
    .addr_i(addr[1:0]), .wdata_i(wdata[1:0]), .ready_o(f_ready), .err_o(f_err),
    .rdata_o(f_rdata), .mem_ready_i(mr), .mem_resp_i(resp), .mem_rdata_i(mrdata),
    .mem_addr_o(f_addr), .mem_trans_o(f_trans), .mem_write_o(f_write), .mem_wdata_o(f_wdata)
  );

  mem_if_arb #(.DWidth(32), .NumCh(4), .ArbMode(ArbRr)) u_rr (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .write_i(wr),
    .addr_i(addr), .wdata_i(wdata), .ready_o(r_ready), .err_o(r_err),
    .rdata_o(r_rdata), .mem_ready_i(mr), .mem_resp_i(resp), .mem_rdata_i(mrdata),
    .mem_addr_o(r_addr), .mem_trans_o(r_trans), .mem_write_o(r_write), .mem_wdata_o(r_wdata)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    req = '0; wr = '0; addr = '0; wdata = '0; mr = 1'b1; resp = 1'b0; mrdata = '0;
  endtask

  // Leaves time at posedge+1 with reset released.
  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Directed cycle table for the fixed-priority instance
  typedef struct {
    logic [1:0]  req;
    logic [1:0]  wr;
    logic [31:0] a0;
    logic [31:0] wd0;
    logic        mr;
    logic        resp;
    logic [31:0] mrd;
    logic        e_trans;
    logic [31:0] e_addr;
    logic        e_write;
    logic [31:0] e_wdata;
    logic [1:0]  e_rdy;
    logic [1:0]  e_err;
    logic [31:0] e_rd0;
    logic [31:0] e_rd1;
  } vec_t;

  vec_t vec[13];

  // Reference model: in-flight transfers as a queue, plain rotating scan for grants
  typedef struct {
    int          ch;
    logic        wr;
    logic [31:0] wd;
  } xfer_t;

  xfer_t       q[$];
  int          ptr;
  logic [31:0] last_addr;
  logic [31:0] rd_m[4];

  task automatic run_random(input bit sel, input int cycles);
    int          nch;
    int          gnt;
    int          ch;
    bit          comp;
    logic [3:0]  e_rdy, e_err, a_rdy, a_err;
    logic [31:0] e_rd;
    xfer_t       x;
    nch = sel ? 4 : 2;
    do_reset();
    q.delete();
    ptr = 0;
    last_addr = '0;
    for (int i = 0; i < 4; i++) rd_m[i] = '0;
    for (int c = 0; c < cycles; c++) begin
      for (int i = 0; i < 4; i++) begin
        req[i]   = ($urandom_range(0, 9) < 6);
        wr[i]    = $urandom_range(0, 1);
        addr[i]  = $urandom;
        wdata[i] = $urandom;
      end
      mr     = ($urandom_range(0, 3) != 0);
      resp   = ($urandom_range(0, 4) == 0);
      mrdata = $urandom;
      @(negedge clk);
      comp = (q.size() > 0) && mr;
      gnt  = -1;
      if (mr) begin
        for (int k = 0; k < nch; k++) begin
          ch = sel ? (ptr + k) % nch : k;
          if (gnt < 0 && req[ch]) gnt = ch;
        end
      end
      e_rdy = '0;
      e_err = '0;
      if (comp) begin
        e_rdy[q[0].ch] = 1'b1;
        e_err[q[0].ch] = resp;
      end
      a_rdy = sel ? r_ready : {2'b00, f_ready};
      a_err = sel ? r_err : {2'b00, f_err};
      chk("rnd_ready", 32'(a_rdy), 32'(e_rdy));
      chk("rnd_err", 32'(a_err), 32'(e_err));
      chk("rnd_trans", 32'(sel ? r_trans : f_trans), 32'(gnt >= 0));
      chk("rnd_addr", sel ? r_addr : f_addr, (gnt >= 0) ? addr[gnt] : last_addr);
      chk("rnd_write", 32'(sel ? r_write : f_write), (gnt >= 0) ? 32'(wr[gnt]) : 32'd0);
      chk("rnd_wdata", sel ? r_wdata : f_wdata, (q.size() > 0) ? q[0].wd : 32'd0);
      for (int i = 0; i < nch; i++) begin
        e_rd = (comp && !q[0].wr && q[0].ch == i) ? mrdata : rd_m[i];
        chk("rnd_rdata", sel ? r_rdata[i] : f_rdata[i], e_rd);
      end
      if (comp) begin
        if (!q[0].wr) rd_m[q[0].ch] = mrdata;
        void'(q.pop_front());
      end
      if (gnt >= 0) begin
        x.ch = gnt;
        x.wr = wr[gnt];
        x.wd = wdata[gnt];
        q.push_back(x);
        last_addr = addr[gnt];
        if (sel) ptr = (gnt + 1) % nch;
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    vec[0]  = '{2'b00, 2'b00, 32'h0,   32'h0,        1, 0, 32'h0,        0, 32'h0,   0, 32'h0,        2'b00, 2'b00, 32'h0,        32'h0};
    vec[1]  = '{2'b01, 2'b00, 32'h100, 32'h0,        1, 0, 32'h0,        1, 32'h100, 0, 32'h0,        2'b00, 2'b00, 32'h0,        32'h0};
    vec[2]  = '{2'b00, 2'b00, 32'h100, 32'h0,        1, 0, 32'hDEADBEEF, 0, 32'h100, 0, 32'h0,        2'b01, 2'b00, 32'hDEADBEEF, 32'h0};
    vec[3]  = '{2'b00, 2'b00, 32'h100, 32'h0,        1, 0, 32'h0,        0, 32'h100, 0, 32'h0,        2'b00, 2'b00, 32'hDEADBEEF, 32'h0};
    vec[4]  = '{2'b01, 2'b01, 32'h200, 32'h12345678, 1, 0, 32'h0,        1, 32'h200, 1, 32'h0,        2'b00, 2'b00, 32'hDEADBEEF, 32'h0};
    vec[5]  = '{2'b01, 2'b01, 32'h200, 32'h12345678, 0, 0, 32'h0,        0, 32'h200, 0, 32'h12345678, 2'b00, 2'b00, 32'hDEADBEEF, 32'h0};
    vec[6]  = '{2'b01, 2'b01, 32'h200, 32'h12345678, 0, 0, 32'h0,        0, 32'h200, 0, 32'h12345678, 2'b00, 2'b00, 32'hDEADBEEF, 32'h0};
    vec[7]  = '{2'b00, 2'b01, 32'h200, 32'h12345678, 1, 0, 32'hBAD0BAD0, 0, 32'h200, 0, 32'h12345678, 2'b01, 2'b00, 32'hDEADBEEF, 32'h0};
    vec[8]  = '{2'b10, 2'b00, 32'h400, 32'h0,        1, 0, 32'h0,        1, 32'h300, 0, 32'h0,        2'b00, 2'b00, 32'hDEADBEEF, 32'h0};
    vec[9]  = '{2'b01, 2'b00, 32'h400, 32'h0,        1, 1, 32'hE0E0E0E0, 1, 32'h400, 0, 32'h0,        2'b10, 2'b10, 32'hDEADBEEF, 32'hE0E0E0E0};
    vec[10] = '{2'b01, 2'b00, 32'h104, 32'h0,        1, 0, 32'h11111111, 1, 32'h104, 0, 32'h0,        2'b01, 2'b00, 32'h11111111, 32'hE0E0E0E0};
    vec[11] = '{2'b00, 2'b00, 32'h104, 32'h0,        1, 0, 32'h22222222, 0, 32'h104, 0, 32'h0,        2'b01, 2'b00, 32'h22222222, 32'hE0E0E0E0};
    vec[12] = '{2'b00, 2'b00, 32'h104, 32'h0,        1, 0, 32'h0,        0, 32'h104, 0, 32'h0,        2'b00, 2'b00, 32'h22222222, 32'hE0E0E0E0};

    // Reset values on both instances
    rst_n = 1'b0;
    idle_inputs();
    mr = 1'b0;
    #12;
    chk("rst_f_addr", f_addr, 32'h0);
    chk("rst_f_trans", 32'(f_trans), 32'h0);
    chk("rst_f_misc", {f_ready, f_err, f_write, 27'h0}, 32'h0);
    chk("rst_f_wdata", f_wdata, 32'h0);
    chk("rst_f_rdata", f_rdata[0] | f_rdata[1], 32'h0);
    chk("rst_r_addr", r_addr, 32'h0);
    chk("rst_r_misc", {r_ready, r_err, r_trans, r_write, 22'h0}, 32'h0);
    chk("rst_r_rdata", r_rdata[0] | r_rdata[1] | r_rdata[2] | r_rdata[3], 32'h0);

    // Directed table on the fixed-priority instance
    do_reset();
    for (int i = 0; i < 13; i++) begin
      req = '0; wr = '0;
      req[1:0] = vec[i].req;
      wr[1:0]  = vec[i].wr;
      addr[0]  = vec[i].a0;
      addr[1]  = 32'h300;
      wdata[0] = vec[i].wd0;
      wdata[1] = 32'h0;
      mr       = vec[i].mr;
      resp     = vec[i].resp;
      mrdata   = vec[i].mrd;
      @(negedge clk);
      chk($sformatf("vec%0d_trans", i), 32'(f_trans), 32'(vec[i].e_trans));
      chk($sformatf("vec%0d_addr", i), f_addr, vec[i].e_addr);
      chk($sformatf("vec%0d_write", i), 32'(f_write), 32'(vec[i].e_write));
      chk($sformatf("vec%0d_wdata", i), f_wdata, vec[i].e_wdata);
      chk($sformatf("vec%0d_ready", i), 32'(f_ready), 32'(vec[i].e_rdy));
      chk($sformatf("vec%0d_err", i), 32'(f_err), 32'(vec[i].e_err));
      chk($sformatf("vec%0d_rdata0", i), f_rdata[0], vec[i].e_rd0);
      chk($sformatf("vec%0d_rdata1", i), f_rdata[1], vec[i].e_rd1);
      @(posedge clk);
      #1;
    end

    // Fixed priority: ch1 starves while ch0 keeps requesting
    do_reset();
    req = 4'b0011;
    addr[0] = 32'hA0;
    addr[1] = 32'hA1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("fix_addr", f_addr, 32'hA0);
      chk("fix_no_ch1", 32'(f_ready[1]), 32'h0);
      @(posedge clk);
      #1;
    end

    // Round-robin with all four channels requesting
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 4; i++) addr[i] = 32'h1000 + 32'(i);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rr_trans", 32'(r_trans), 32'h1);
      chk("rr_addr", r_addr, 32'h1000 + 32'(i % 4));
      @(posedge clk);
      #1;
    end

    // Reset asserted during a wait state
    do_reset();
    req = 4'b0001; wr = 4'b0001; addr[0] = 32'h500; wdata[0] = 32'hCAFE;
    @(posedge clk);
    #1;
    mr = 1'b0;
    @(negedge clk);
    chk("wait_addr", f_addr, 32'h500);
    chk("wait_wdata", f_wdata, 32'hCAFE);
    #2;
    rst_n = 1'b0;
    req = '0;
    #1;
    chk("midrst_addr", f_addr, 32'h0);
    chk("midrst_wdata", f_wdata, 32'h0);
    chk("midrst_misc", {f_ready, f_err, f_trans, f_write, 26'h0}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    mr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("postrst_ready", 32'(f_ready), 32'h0);
      chk("postrst_trans", 32'(f_trans), 32'h0);
    end

    // Randomized runs against the reference model
    run_random(1'b1, 300);
    run_random(1'b0, 300);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_if_arb.md
# mem_if_arb

Parametrised successor to the core-to-memory interface: arbitrates NumCh independent request channels (core data, core instruction, DMA, debug, …) onto one single-outstanding, address/data-pipelined memory bus. Adds configurable fixed-priority or round-robin arbitration, error reporting per channel, wait-state-safe address holding, and write data registered into the data phase. Sits between the scalar core (plus any extra masters) and the memory/bus fabric.

## Interface
- DWidth, 32, address/data width
- NumCh, 2, number of request channels (2..8)
- ArbMode, 0, 0 = fixed priority (channel 0 highest), 1 = round-robin

- clk_i  in  1  clock
- rst_ni  in  1  asynchronous, active-low reset
- req_i  in  NumCh  per-channel request; held until that channel's ready_o
- write_i  in  NumCh  per-channel write enable
- addr_i  in  NumCh×DWidth  per-channel address
- wdata_i  in  NumCh×DWidth  per-channel write data
- ready_o  out  NumCh  one-cycle transfer-complete pulse
- err_o  out  NumCh  qualifies ready_o: 1 = bus ERROR response
- rdata_o  out  NumCh×DWidth  per-channel read data
- mem_ready_i  in  1  bus ready
- mem_resp_i  in  1  bus response (pkg_resp OKAY/ERROR)
- mem_rdata_i  in  DWidth  bus read data
- mem_addr_o  out  DWidth  bus address
- mem_trans_o  out  1  IDLE/NONSEQ (pkg_trans)
- mem_write_o  out  1  bus write
- mem_wdata_o  out  DWidth  bus write data (valid in data phase)

## Operation
- States: StIdle (no transfer in data phase), StData (one transfer in data phase; owner index, write flag, wdata registered).
- Issue slot: cycle where state is StIdle and mem_ready_i=1, or state is StData and mem_ready_i=1 (data phase completing). Only in an issue slot may arbitration grant.
- Grant: among req_i bits; ArbMode 0 → lowest index; ArbMode 1 → first requester at or after rr_ptr, rr_ptr ← grant+1 (mod NumCh) on each grant.
- On grant g: mem_trans_o=NONSEQ, mem_addr_o=addr_i[g], mem_write_o=write_i[g]; register g, write_i[g], wdata_i[g]; next state StData. No grant in slot → mem_trans_o=IDLE, next state StIdle (if completing) or stays StIdle.
- Completing channel is re-arbitrated with its current inputs in the same cycle (back-to-back transfers allowed; its req_i then denotes the next request).
- StData, mem_ready_i=0: wait state; mem_trans_o=IDLE, mem_addr_o holds last issued address, mem_write_o=0, no grant, no ready_o.
- StData, mem_ready_i=1: ready_o[owner]=1, err_o[owner]=(mem_resp_i==ERROR); read → rdata_o[owner]=mem_rdata_i combinationally and latched into owner's rdata register; non-owners show their latched rdata.
- mem_wdata_o = registered wdata while in StData, else 0.
- Non-granted channels keep req_i asserted; no starvation under ArbMode 1 (max wait NumCh-1 transfers).

## Timing
- Reset values: state StIdle, rr_ptr 0, mem_trans_o IDLE, mem_addr_o 0, mem_write_o 0, mem_wdata_o 0, ready_o 0, err_o 0, all rdata_o 0.
- Latency: address issued cycle t (same cycle req_i seen, if issue slot); ready_o earliest t+1; +1 per wait state.
- Throughput: 1 transfer/cycle with zero-wait memory.
- ready_o, err_o, rdata_o (owner) are combinational from mem_* in the completing cycle.
- Simultaneous requests: exactly one grant per slot; ERROR response consumes the slot like OKAY (next grant still allowed).
- Reset mid-transfer: immediate return to reset values; aborted transfer produces no ready_o.

## Structure
- pkg_trans (IDLE/NONSEQ), pkg_resp (OKAY/ERROR, SUCCESS), pkg_bool reused; new pkg_arb holds arb_mode_e {ArbFixed, ArbRr} and the mem_if_arb_state_e enum.
- Sub-module arb_rr: combinational grant + registered rr_ptr (fixed-priority mode bypasses pointer).
- Registers via D_FF: state, owner index, write flag, wdata, last address, NumCh rdata latches.

## Test plan
- Single read ch0, addr 0x100, zero-wait, rdata 0xDEADBEEF → NONSEQ at t, ready_o[0]=1 at t+1, rdata_o[0]=0xDEADBEEF held afterwards.
- ch0 write 0x200/0x12345678 with 2 wait states → mem_addr_o holds 0x200, mem_trans_o IDLE during waits, mem_wdata_o=0x12345678, ready_o[0] at t+3.
- ArbMode 0, ch0 and ch1 requesting continuously → ch1 never granted while ch0 requests; ArbMode 1, NumCh=4 all requesting → grants 0,1,2,3,0 on consecutive cycles.
- ERROR response on ch1 read → ready_o[1]=1, err_o[1]=1 one cycle, pending ch0 granted same cycle.
- Back-to-back: ch0 completes and presents new addr 0x104 same cycle → NONSEQ 0x104 that cycle, no bubble.
- rst_ni low during wait state → all outputs to reset values immediately, no ready_o after release.
